uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
// Shares one uart_host instance among NREQ byte-stream requesters (e.g. CPU shim, debug monitor).
// - After reset, programs the uart_host CTRL register once.
// - Then arbitrates round-robin over requesters, with packet lock until 'last'.
// - Polls STAT.txf_full and writes granted bytes into the DATA register (TX FIFO). Never touches the RX side.
// PARAMETERS
// NREQ        2       number of requesters (2..4)
// INIT_CTRL   8'h04   value written to CTRL after reset (115200 Bd, no parity, no hwflow, no IRQs)
// LOCK_TMO    255     idle cycles a locked requester may hold the grant without valid before forced release (8-bit)
// PORTS
// clk            in   1        system clock (48MHz)
// resetn         in   1        reset, asynchronous assert, active low
// req_data_i     in   8*NREQ   byte from requester k at [8k+7:8k]
// req_valid_i    in   NREQ     requester k has a byte; must hold data/valid stable until ready
// req_last_i     in   NREQ     byte is last of packet; qualified by valid
// req_ready_o    out  NREQ     1T: byte of requester k accepted this cycle (valid&ready)
// grant_o        out  NREQ     one-hot current owner, 0 when none
// busy_o         out  1        high in any state except IDLE
// host_d_o       out  8        write data to uart_host reg_d_i
// host_d_i       in   8        read data from uart_host reg_d_o (combinational in same cycle)
// host_wr_o      out  1        to uart_host reg_wr_i
// host_rd_o      out  1        to uart_host reg_rd_i
// host_cs_ctrl_o out  1        to reg_cs_ctrl_i
// host_cs_stat_o out  1        to reg_cs_stat_i
// host_cs_data_o out  1        to reg_cs_data_i
// BEHAVIOUR
// - Reset (resetn=0, async): state=INIT, rr pointer=0, grant_o=0, lock=0, timeout ctr=0.
//   All host strobes and req_ready_o are 0; host_d_o=0; busy_o=1.
// - Strobes decode from state only; at most one cs_* is high; host_rd_o never with host_cs_data_o (no RX dequeue).
// - INIT (1 cycle, first cycle after reset release): host_wr_o=1, host_cs_ctrl_o=1, host_d_o=INIT_CTRL. -> IDLE.
// - IDLE: if any req_valid_i:
//   - grant = first valid index searching from rr, wrapping NREQ-1 -> 0; grant_o registered.
//   - -> POLL. Else stay, grant_o=0.
// - POLL: host_rd_o=1, host_cs_stat_o=1; sample host_d_i[3] (txf_full) same cycle.
//   - Full, or granted valid=0: stay POLL. Valid=0 while locked also increments the timeout ctr.
//   - Otherwise -> WRITE.
//   - Timeout ctr reaching LOCK_TMO: release lock, rr=grant+1 mod NREQ, -> IDLE.
// - WRITE (1 cycle): host_wr_o=1, host_cs_data_o=1, host_d_o=granted req_data.
//   - req_ready_o[grant]=1 (1T). Timeout ctr cleared.
//   - If req_last_i[grant]: lock=0, rr=grant+1 mod NREQ, -> IDLE. Else lock=1, -> POLL (same grant).
// - Throughput: 2 clk per byte while FIFO not full. Latency: valid in IDLE -> ready 2 cycles later (IDLE, POLL, WRITE).
// - Grant changes only in IDLE; requests from others during a locked packet are ignored until release.
// - Simultaneous valids in IDLE: lowest index at/after rr wins.
// - rr pointer and counter widths: clog2(NREQ) and 8 bits; modulo wrap, no overflow.
// - Reset mid-packet: abandon immediately, no partial write strobe; INIT rewrites CTRL.
// TESTING
// 1 Release reset -> exactly one cycle wr+cs_ctrl with d=8'h04, then IDLE, busy_o=0.
// 2 Req0 sends 3 bytes 8'h41,8'h42,8'h43 (last on third), host stat=8'h04 -> three WRITE cycles 2 clk apart, data in order, grant_o=2'b01 throughout.
// 3 Req0 and req1 valid together in IDLE after reset -> req0 served first. Single-byte packets alternate 0,1,0,1.
// 4 Req1 mid-packet (no last), req0 valid -> req0 not granted until req1 asserts last.
// 5 Stat bit3=1 for 10 cycles during packet -> stays POLL, no wr strobes, then writes once bit3=0.
// 6 Req0 locked drops valid -> after 255 POLL cycles forced release, req1 granted. Async reset mid-POLL -> strobes 0 immediately.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NREQ byte streams share one uart_host TX FIFO.
// Programs CTRL once after reset, then polls STAT and writes granted bytes to DATA.
module uart_tx_arbiter #(
  parameter int         NREQ      = 2,
  parameter logic [7:0] INIT_CTRL = 8'h04,
  parameter logic [7:0] LOCK_TMO  = 8'd255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o,
  output logic [7:0]        host_d_o,
  input  logic [7:0]        host_d_i,
  output logic              host_wr_o,
  output logic              host_rd_o,
  output logic              host_cs_ctrl_o,
  output logic              host_cs_stat_o,
  output logic              host_cs_data_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_POLL, S_WRITE} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_rr, w_rr_nxt;
  logic [IW-1:0]   r_gidx, w_gidx_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic            r_lock, w_lock_nxt;
  logic [7:0]      r_tmo, w_tmo_nxt;
  logic [7:0]      w_tmo_inc;
  logic [IW-1:0]   w_pick;
  logic            w_any;
  logic            w_gvalid;
  logic            w_full;
  logic [7:0]      w_gdata;
  int              w_c;
  logic            w_unused_stat;

  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] v);
    return (v == IW'(NREQ-1)) ? '0 : v + 1'b1;
  endfunction

  assign w_gvalid      = |(req_valid_i & r_grant);
  assign w_full        = host_d_i[3];
  assign w_gdata       = req_data_i[8*int'(r_gidx) +: 8];
  assign w_tmo_inc     = r_tmo + 8'd1;
  assign w_unused_stat = ^{host_d_i[7:4], host_d_i[2:0]};

  // Scan from the highest offset down so the valid closest to r_rr wins.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_c    = 0;
    for (int i = NREQ-1; i >= 0; i--) begin
      w_c = (int'(r_rr) + i) % NREQ;
      if (req_valid_i[w_c]) begin
        w_pick = IW'(w_c);
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_gidx_nxt  = r_gidx;
    w_grant_nxt = r_grant;
    w_lock_nxt  = r_lock;
    w_tmo_nxt   = r_tmo;
    case (r_state)
      S_INIT: w_state_nxt = S_IDLE;
      S_IDLE: begin
        w_grant_nxt = '0;
        if (w_any) begin
          w_gidx_nxt  = w_pick;
          w_grant_nxt = NREQ'(1) << w_pick;
          w_state_nxt = S_POLL;
        end
      end
      S_POLL: begin
        if (!w_gvalid && r_lock) begin
          // Owner went quiet mid-packet: give up the lock after LOCK_TMO polls.
          if (w_tmo_inc == LOCK_TMO) begin
            w_tmo_nxt   = '0;
            w_lock_nxt  = 1'b0;
            w_grant_nxt = '0;
            w_rr_nxt    = f_inc(r_gidx);
            w_state_nxt = S_IDLE;
          end else begin
            w_tmo_nxt = w_tmo_inc;
          end
        end else if (w_gvalid && !w_full) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_tmo_nxt = '0;
        if (req_last_i[r_gidx]) begin
          w_lock_nxt  = 1'b0;
          w_grant_nxt = '0;
          w_rr_nxt    = f_inc(r_gidx);
          w_state_nxt = S_IDLE;
        end else begin
          w_lock_nxt  = 1'b1;
          w_state_nxt = S_POLL;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // resetn masks the decode so an async reset (which lands in INIT) drops every strobe at once.
  always_comb begin
    host_wr_o      = 1'b0;
    host_rd_o      = 1'b0;
    host_cs_ctrl_o = 1'b0;
    host_cs_stat_o = 1'b0;
    host_cs_data_o = 1'b0;
    host_d_o       = '0;
    req_ready_o    = '0;
    if (resetn) begin
      case (r_state)
        S_INIT: begin
          host_wr_o      = 1'b1;
          host_cs_ctrl_o = 1'b1;
          host_d_o       = INIT_CTRL;
        end
        S_POLL: begin
          host_rd_o      = 1'b1;
          host_cs_stat_o = 1'b1;
        end
        S_WRITE: begin
          host_wr_o      = 1'b1;
          host_cs_data_o = 1'b1;
          host_d_o       = w_gdata;
          req_ready_o    = r_grant;
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = (r_state != S_IDLE);
  assign grant_o = r_grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_INIT;
      r_rr    <= '0;
      r_gidx  <= '0;
      r_grant <= '0;
      r_lock  <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_gidx  <= w_gidx_nxt;
      r_grant <= w_grant_nxt;
      r_lock  <= w_lock_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed steps plus random packets, checked against a
// packet-level round-robin model of which requester's bytes reach the TX FIFO in what order.
`define CHK(TAG, OBS, EXP) \
  begin \
    checks++; \
    assert ((OBS) === (EXP)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_uart_tx_arbiter;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [8*NREQ-1:0] req_data_i = '0;
  logic [NREQ-1:0]   req_valid_i = '0;
  logic [NREQ-1:0]   req_last_i = '0;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ-1:0]   grant_o;
  logic              busy_o;
  logic [7:0]        host_d_o;
  logic [7:0]        stat = 8'h04;
  logic              host_wr_o, host_rd_o, host_cs_ctrl_o, host_cs_stat_o, host_cs_data_o;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .INIT_CTRL(8'h04), .LOCK_TMO(8'd255)) dut (
    .clk(clk), .resetn(resetn),
    .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o), .busy_o(busy_o),
    .host_d_o(host_d_o), .host_d_i(stat), .host_wr_o(host_wr_o), .host_rd_o(host_rd_o),
    .host_cs_ctrl_o(host_cs_ctrl_o), .host_cs_stat_o(host_cs_stat_o), .host_cs_data_o(host_cs_data_o)
  );

  int checks = 0, errors = 0, ncyc = 0, n_bad = 0, n_ctrl = 0, m_rr = 0;
  logic [8:0] q0[$], q1[$], mq0[$], mq1[$];   // {last, data}
  logic [7:0] wq[$], exp_b[$];
  logic [1:0] gq[$], exp_g[$];
  int         wc[$];
  int         gapc[NREQ], force_gap[NREQ];
  bit         rnd_gaps = 0, rnd_stat = 0;
  logic       p_poll = 0, s_full;
  logic [NREQ-1:0] p_ready = '0;

  initial begin #1_000_000; $display("FAIL watchdog expired"); $fatal(1); end

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction
  function automatic logic [8:0] qfront(input int k);
    if (k == 0) return q0[0];
    return q1[0];
  endfunction
  task automatic qpop(input int k);
    if (k == 0) q0.delete(0); else q1.delete(0);
  endtask
  task automatic qload(input int k, input logic [8:0] b);
    if (k == 0) q0.push_back(b); else q1.push_back(b);
  endtask
  task automatic qpush(input int k, input logic [8:0] b);
    qload(k, b);
    if (k == 0) mq0.push_back(b); else mq1.push_back(b);
  endtask

  // Whole packets go out in turn; after requester k finishes, search restarts at k+1.
  task automatic model_run();
    int k;
    logic [8:0] b;
    while (mq0.size() + mq1.size() > 0) begin
      if (m_rr == 0) k = (mq0.size() > 0) ? 0 : 1;
      else           k = (mq1.size() > 0) ? 1 : 0;
      do begin
        b = (k == 0) ? mq0.pop_front() : mq1.pop_front();
        exp_b.push_back(b[7:0]);
        exp_g.push_back((k == 0) ? 2'b01 : 2'b10);
      end while (!b[8] && ((k == 0) ? mq0.size() : mq1.size()) > 0);
      m_rr = (k + 1) % NREQ;
    end
  endtask

  task automatic clear_streams();
    wq.delete(); gq.delete(); wc.delete(); exp_b.delete(); exp_g.delete();
  endtask

  // One clock: observe at the falling edge, then retire accepted bytes and drive the next inputs.
  task automatic cyc();
    logic [8:0] b;
    @(negedge clk);
    ncyc++;
    s_full = stat[3];
    if (host_wr_o && host_cs_ctrl_o) n_ctrl++;
    if (host_wr_o && host_cs_data_o) begin
      `CHK("write_follows_clear_poll", (p_poll && !s_full), 1'b1)
      wq.push_back(host_d_o); gq.push_back(grant_o); wc.push_back(ncyc);
      if (req_ready_o !== grant_o) n_bad++;
    end else if (req_ready_o !== '0) n_bad++;
    if ($countones({host_cs_ctrl_o, host_cs_stat_o, host_cs_data_o}) > 1) n_bad++;
    if (host_rd_o && host_cs_data_o) n_bad++;
    for (int k = 0; k < NREQ; k++) if (req_ready_o[k] && !req_valid_i[k]) n_bad++;
    p_poll = resetn && host_rd_o && host_cs_stat_o;
    for (int k = 0; k < NREQ; k++) begin
      if (p_ready[k] && qsize(k) > 0) begin
        b = qfront(k);
        qpop(k);
        if (!b[8]) begin
          if (force_gap[k] > 0) begin gapc[k] = force_gap[k]; force_gap[k] = 0; end
          else if (rnd_gaps) gapc[k] = $urandom_range(0, 3);
        end
      end
    end
    p_ready = req_ready_o;
    for (int k = 0; k < NREQ; k++) begin
      if (qsize(k) > 0 && gapc[k] == 0) begin
        b = qfront(k);
        req_valid_i[k] = 1'b1;
        req_last_i[k]  = b[8];
        req_data_i[8*k +: 8] = b[7:0];
      end else begin
        req_valid_i[k] = 1'b0;
        req_last_i[k]  = 1'($urandom_range(0, 1));
        req_data_i[8*k +: 8] = 8'($urandom);
        if (gapc[k] > 0) gapc[k]--;
      end
    end
    if (rnd_stat) stat = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h04;
  endtask

  task automatic run_drain(input int maxc, input string tag);
    int n;
    n = 0;
    do begin cyc(); n++; end
    while ((q0.size() != 0 || q1.size() != 0 || busy_o) && n < maxc);
    `CHK(tag, (n < maxc), 1'b1)
  endtask

  task automatic check_stream(input string tag);
    string tg;
    tg = {tag, "_count"};
    `CHK(tg, wq.size(), exp_b.size())
    for (int i = 0; i < exp_b.size() && i < wq.size(); i++) begin
      tg = $sformatf("%s_byte%0d", tag, i);
      `CHK(tg, wq[i], exp_b[i])
      tg = $sformatf("%s_grant%0d", tag, i);
      `CHK(tg, gq[i], exp_g[i])
    end
  endtask

  task automatic reset_release();
    @(posedge clk); #1 resetn = 1'b1;
    cyc();
    `CHK("init_strobes", {host_wr_o, host_rd_o, host_cs_ctrl_o, host_cs_stat_o, host_cs_data_o}, 5'b10100)
    `CHK("init_data", host_d_o, 8'h04)
    `CHK("init_busy", busy_o, 1'b1)
    cyc();
    `CHK("idle_busy", busy_o, 1'b0)
    `CHK("idle_strobes", {host_wr_o, host_rd_o, host_cs_ctrl_o, host_cs_stat_o, host_cs_data_o}, 5'b00000)
    `CHK("idle_grant", grant_o, 2'b00)
  endtask

  initial begin
    int np, len, t0, w, npoll;
    for (int k = 0; k < NREQ; k++) begin gapc[k] = 0; force_gap[k] = 0; end

    // 1: reset state, then exactly one CTRL write
    repeat (3) cyc();
    `CHK("rst_strobes", {host_wr_o, host_rd_o, host_cs_ctrl_o, host_cs_stat_o, host_cs_data_o}, 5'b00000)
    `CHK("rst_ready", req_ready_o, 2'b00)
    `CHK("rst_grant", grant_o, 2'b00)
    `CHK("rst_busy", busy_o, 1'b1)
    `CHK("rst_data", host_d_o, 8'h00)
    reset_release();

    // 3: simultaneous single-byte packets alternate, req0 first
    clear_streams();
    qpush(0, {1'b1, 8'h10}); qpush(0, {1'b1, 8'h11});
    qpush(1, {1'b1, 8'h20}); qpush(1, {1'b1, 8'h21});
    model_run();
    run_drain(200, "t3_drain");
    check_stream("t3");

    // 2: three-byte packet, one byte every 2 clocks, 2 clocks after valid
    clear_streams();
    qpush(0, {1'b0, 8'h41}); qpush(0, {1'b0, 8'h42}); qpush(0, {1'b1, 8'h43});
    model_run();
    cyc();
    t0 = ncyc;
    run_drain(200, "t2_drain");
    check_stream("t2");
    `CHK("t2_latency", wc[0] - t0, 2)
    `CHK("t2_gap1", wc[1] - wc[0], 2)
    `CHK("t2_gap2", wc[2] - wc[1], 2)

    // 4: req0 waits while req1 holds a locked packet
    clear_streams();
    qpush(1, {1'b0, 8'h51}); qpush(1, {1'b0, 8'h52}); qpush(1, {1'b1, 8'h53});
    model_run();
    for (int i = 0; i < 20 && wq.size() == 0; i++) cyc();
    qpush(0, {1'b1, 8'h61});
    model_run();
    run_drain(200, "t4_drain");
    check_stream("t4");

    // 5: FIFO full for 10 cycles mid-packet
    clear_streams();
    qpush(0, {1'b0, 8'h71}); qpush(0, {1'b0, 8'h72}); qpush(0, {1'b1, 8'h73});
    model_run();
    for (int i = 0; i < 20 && wq.size() == 0; i++) cyc();
    stat = 8'h0C;
    npoll = 0;
    repeat (10) begin cyc(); if (host_rd_o && host_cs_stat_o) npoll++; end
    `CHK("t5_full_polls", npoll, 10)
    `CHK("t5_no_write_when_full", wq.size(), 1)
    stat = 8'h04;
    t0 = ncyc;
    run_drain(200, "t5_drain");
    check_stream("t5");
    `CHK("t5_resume", wc[1] - t0, 1)

    // random packets, random in-packet gaps, random FIFO-full
    clear_streams();
    for (int k = 0; k < NREQ; k++) begin
      np = $urandom_range(3, 6);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) qpush(k, {(j == len-1), 8'($urandom)});
      end
    end
    model_run();
    rnd_gaps = 1; rnd_stat = 1;
    run_drain(4000, "rnd_drain");
    rnd_gaps = 0; rnd_stat = 0; stat = 8'h04;
    check_stream("rnd");

    // 6: locked owner goes quiet -> forced release after 255 polls, req1 served
    clear_streams();
    force_gap[0] = 400;
    qload(0, {1'b0, 8'h81}); qload(0, {1'b0, 8'h82}); qload(0, {1'b1, 8'h83});
    for (int i = 0; i < 20 && wq.size() == 0; i++) cyc();
    `CHK("t6_first_byte", wq.size(), 1)
    w = ncyc;
    qload(1, {1'b1, 8'h91});
    clear_streams();
    npoll = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (host_rd_o && host_cs_stat_o && grant_o === 2'b01) npoll++;
      else break;
    end
    `CHK("t6_tmo_polls", npoll, 255)
    for (int i = 0; i < 10 && wq.size() == 0; i++) cyc();
    `CHK("t6_req1_grant", gq[0], 2'b10)
    `CHK("t6_req1_byte", wq[0], 8'h91)
    `CHK("t6_req1_time", wc[0] - w, 258)

    // async reset while stuck in POLL
    qload(1, {1'b1, 8'h92});
    stat = 8'h0C;
    repeat (5) cyc();
    `CHK("t6_in_poll", {host_rd_o, host_cs_stat_o, grant_o}, 4'b1110)
    #2 resetn = 1'b0;
    #1;
    `CHK("t6_rst_strobes", {host_wr_o, host_rd_o, host_cs_ctrl_o, host_cs_stat_o, host_cs_data_o}, 5'b00000)
    `CHK("t6_rst_grant", grant_o, 2'b00)
    `CHK("t6_rst_busy", busy_o, 1'b1)
    `CHK("t6_rst_data", host_d_o, 8'h00)
    q0.delete(); q1.delete(); p_ready = '0; stat = 8'h04;
    for (int k = 0; k < NREQ; k++) begin gapc[k] = 0; force_gap[k] = 0; end
    repeat (2) cyc();
    reset_release();

    `CHK("ctrl_write_count", n_ctrl, 2)
    `CHK("bus_invariants", n_bad, 0)
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
